// File: rtl/axi_default_slave.sv
// Fall-through AXI responder: completes every read and write handshake and answers DECERR.
// Read and write sides are independent FSMs; all handshake outputs come straight from registers.
module axi_default_slave #(
    parameter int                 ID_W       = 8,
    parameter int                 DATA_W     = 32,
    parameter int                 LEN_W      = 4,
    parameter logic [DATA_W-1:0]  RDATA_FILL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_W-1:0]       AWID,
    input  logic [31:0]           AWADDR,
    input  logic [LEN_W-1:0]      AWLEN,
    input  logic [2:0]            AWSIZE,
    input  logic [1:0]            AWBURST,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [DATA_W-1:0]     WDATA,
    input  logic [DATA_W/8-1:0]   WSTRB,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [ID_W-1:0]       BID,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    input  logic [ID_W-1:0]       ARID,
    input  logic [31:0]           ARADDR,
    input  logic [LEN_W-1:0]      ARLEN,
    input  logic [2:0]            ARSIZE,
    input  logic [1:0]            ARBURST,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [ID_W-1:0]       RID,
    output logic [DATA_W-1:0]     RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST,
    output logic                  RVALID,
    input  logic                  RREADY
);
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA} r_state_t;

    w_state_t          w_state;
    r_state_t          r_state;
    logic [ID_W-1:0]   bid_r;
    logic [ID_W-1:0]   rid_r;
    logic [LEN_W-1:0]  rlen_r;
    logic [LEN_W-1:0]  cnt;
    logic [DATA_W-1:0] rdata_r;
    logic              awready_r, wready_r, bvalid_r;
    logic              arready_r, rvalid_r, rlast_r;

    // Ignored request fields and write payload are folded here so they register as deliberately unused.
    logic unused_inputs;
    assign unused_inputs = ^{AWADDR, AWLEN, AWSIZE, AWBURST, WDATA, WSTRB,
                             ARADDR, ARSIZE, ARBURST};

    // Write side: the burst is closed by WLAST alone, no beat counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state   <= W_IDLE;
            awready_r <= 1'b1;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bid_r     <= '0;
        end else begin
            case (w_state)
                W_IDLE: if (AWVALID) begin
                    bid_r     <= AWID;
                    awready_r <= 1'b0;
                    wready_r  <= 1'b1;
                    w_state   <= W_DATA;
                end
                W_DATA: if (WVALID && WLAST) begin
                    wready_r <= 1'b0;
                    bvalid_r <= 1'b1;
                    w_state  <= W_RESP;
                end
                W_RESP: if (BREADY) begin
                    bvalid_r  <= 1'b0;
                    awready_r <= 1'b1;
                    w_state   <= W_IDLE;
                end
                default: begin
                    w_state   <= W_IDLE;
                    awready_r <= 1'b1;
                    wready_r  <= 1'b0;
                    bvalid_r  <= 1'b0;
                end
            endcase
        end
    end

    // Read side: RLAST is precomputed one beat ahead so it is a plain register output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= R_IDLE;
            arready_r <= 1'b1;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
            rid_r     <= '0;
            rlen_r    <= '0;
            cnt       <= '0;
            rdata_r   <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (ARVALID) begin
                    rid_r     <= ARID;
                    rlen_r    <= ARLEN;
                    cnt       <= '0;
                    rdata_r   <= RDATA_FILL;
                    arready_r <= 1'b0;
                    rvalid_r  <= 1'b1;
                    rlast_r   <= (ARLEN == '0);
                    r_state   <= R_DATA;
                end
                R_DATA: if (RREADY) begin
                    if (rlast_r) begin
                        rvalid_r  <= 1'b0;
                        rlast_r   <= 1'b0;
                        rdata_r   <= '0;
                        arready_r <= 1'b1;
                        r_state   <= R_IDLE;
                    end else begin
                        cnt     <= cnt + LEN_W'(1);
                        rlast_r <= ((cnt + LEN_W'(1)) == rlen_r);
                    end
                end
                default: begin
                    r_state   <= R_IDLE;
                    arready_r <= 1'b1;
                    rvalid_r  <= 1'b0;
                    rlast_r   <= 1'b0;
                end
            endcase
        end
    end

    assign AWREADY = awready_r;
    assign WREADY  = wready_r;
    assign BVALID  = bvalid_r;
    assign BID     = bid_r;
    assign BRESP   = DECERR;
    assign ARREADY = arready_r;
    assign RVALID  = rvalid_r;
    assign RLAST   = rlast_r;
    assign RID     = rid_r;
    assign RDATA   = rdata_r;
    assign RRESP   = DECERR;
endmodule

// File: tb/tb_axi_default_slave.sv
// Directed bench for axi_default_slave: inputs driven and outputs sampled on the falling edge.
module tb_axi_default_slave;
    localparam int ID_W = 8, DATA_W = 32, LEN_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [ID_W-1:0]   AWID, ARID, BID, RID;
    logic [31:0]       AWADDR, ARADDR;
    logic [LEN_W-1:0]  AWLEN, ARLEN;
    logic [2:0]        AWSIZE, ARSIZE;
    logic [1:0]        AWBURST, ARBURST, BRESP, RRESP;
    logic              AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic              ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic [DATA_W-1:0] WDATA, RDATA;
    logic [DATA_W/8-1:0] WSTRB;

    int errs = 0, checks = 0;

    always #5 clk = ~clk;

    axi_default_slave #(.ID_W(ID_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .RDATA_FILL('0)) dut (
        .clk(clk), .rst(rst),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        int done;
        int bseen;
        logic [4:0] pat;

        rst = 1'b1;
        AWID = '0; AWADDR = 32'h1234_0000; AWLEN = '0; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b0;
        WDATA = 32'hDEAD_BEEF; WSTRB = '1; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = 32'h5678_0000; ARLEN = '0; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b0;
        RREADY = 1'b0;
        step(); step();
        rst = 1'b0;

        // Reset state
        chk("rst_awready", AWREADY, 1);
        chk("rst_arready", ARREADY, 1);
        chk("rst_wready",  WREADY,  0);
        chk("rst_bvalid",  BVALID,  0);
        chk("rst_rvalid",  RVALID,  0);
        chk("rst_rlast",   RLAST,   0);
        chk("rst_bid",     BID,     0);
        chk("rst_rid",     RID,     0);
        chk("rst_rdata",   RDATA,   0);
        chk("rst_bresp",   BRESP,   2'b11);
        chk("rst_rresp",   RRESP,   2'b11);

        // W before AW stalls
        WVALID = 1'b1; WLAST = 1'b1;
        step();
        chk("w_early_stall", WREADY, 0);
        chk("w_early_nob",   BVALID, 0);
        WVALID = 1'b0; WLAST = 1'b0;

        // Single write
        AWID = 8'h15; AWVALID = 1'b1;
        step();
        AWVALID = 1'b0;
        chk("wr_awready_low", AWREADY, 0);
        chk("wr_wready",      WREADY,  1);
        chk("wr_bvalid_early", BVALID, 0);
        WVALID = 1'b1; WLAST = 1'b1;
        step();
        WVALID = 1'b0; WLAST = 1'b0;
        chk("wr_bvalid", BVALID, 1);
        chk("wr_bid",    BID,    8'h15);
        chk("wr_bresp",  BRESP,  2'b11);
        chk("wr_wready_off", WREADY, 0);
        BREADY = 1'b1;
        step();
        BREADY = 1'b0;
        chk("wr_b_done", BVALID,  0);
        chk("wr_idle",   AWREADY, 1);

        // Read burst of 4
        ARID = 8'h2A; ARLEN = 4'd3; ARVALID = 1'b1; RREADY = 1'b1;
        step();
        ARVALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rd_rvalid", RVALID, 1);
            chk("rd_rid",    RID,    8'h2A);
            chk("rd_rdata",  RDATA,  0);
            chk("rd_rresp",  RRESP,  2'b11);
            chk("rd_rlast",  RLAST,  (i == 3));
            chk("rd_arready_low", ARREADY, 0);
            step();
        end
        chk("rd_end_rvalid",  RVALID,  0);
        chk("rd_end_arready", ARREADY, 1);
        RREADY = 1'b0;

        // Read backpressure, ARLEN=1
        ARID = 8'h3C; ARLEN = 4'd1; ARVALID = 1'b1;
        step();
        ARVALID = 1'b0;
        pat = 5'b10100;  // applied LSB first: 0,0,1,0,1
        done = 0;
        for (int k = 0; k < 5; k++) begin
            RREADY = pat[k];
            chk("bp_rvalid", RVALID, 1);
            chk("bp_rid",    RID,    8'h3C);
            chk("bp_rlast",  RLAST,  (done == 1));
            step();
            if (pat[k]) done++;
        end
        RREADY = 1'b0;
        chk("bp_beats",     done,   2);
        chk("bp_end_valid", RVALID, 0);

        // Write with B backpressure
        AWID = 8'h5A; AWVALID = 1'b1;
        step();
        AWVALID = 1'b0; WVALID = 1'b1; WLAST = 1'b1;
        step();
        WVALID = 1'b0; WLAST = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bbp_bvalid", BVALID, 1);
            chk("bbp_bid",    BID,    8'h5A);
            chk("bbp_awready_low", AWREADY, 0);
            step();
        end
        BREADY = 1'b1;
        step();
        BREADY = 1'b0;
        chk("bbp_done", BVALID, 0);

        // Concurrent AW + 16-beat AR
        AWID = 8'h01; AWVALID = 1'b1; ARID = 8'h02; ARLEN = 4'd15; ARVALID = 1'b1;
        chk("cc_awready", AWREADY, 1);
        chk("cc_arready", ARREADY, 1);
        step();
        AWVALID = 1'b0; ARVALID = 1'b0;
        WVALID = 1'b1; WLAST = 1'b1; BREADY = 1'b1; RREADY = 1'b1;
        bseen = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 1) begin WVALID = 1'b0; WLAST = 1'b0; end
            chk("cc_rvalid", RVALID, 1);
            chk("cc_rid",    RID,    8'h02);
            chk("cc_rlast",  RLAST,  (i == 15));
            if (BVALID) begin
                bseen++;
                chk("cc_bid", BID, 8'h01);
            end
            step();
        end
        chk("cc_bcount",   bseen,  1);
        chk("cc_end_rvalid", RVALID, 0);
        BREADY = 1'b0; RREADY = 1'b0;

        // Mid-burst reset on ARLEN=7 after two beats
        ARID = 8'h44; ARLEN = 4'd7; ARVALID = 1'b1; RREADY = 1'b1;
        step();
        ARVALID = 1'b0;
        step(); step();
        chk("mr_rvalid_pre", RVALID, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_rvalid",  RVALID,  0);
        chk("mr_arready", ARREADY, 1);
        for (int k = 0; k < 3; k++) begin
            chk("mr_no_beats", RVALID, 0);
            step();
        end
        ARID = 8'h33; ARLEN = 4'd0; ARVALID = 1'b1;
        step();
        ARVALID = 1'b0;
        chk("mr_single_valid", RVALID, 1);
        chk("mr_single_last",  RLAST,  1);
        chk("mr_single_rid",   RID,    8'h33);
        step();
        chk("mr_single_done",  RVALID, 0);
        RREADY = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
